// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax row normaliser.
package softmax_pkg;

    localparam int EX_W     = 9;   // exponent input width, UQ3.6
    localparam int PROB_W   = 8;   // probability output width, UQ0.8
    localparam int FRAC_OUT = 8;   // fractional bits appended to the dividend

    localparam logic [PROB_W-1:0] PROB_SAT = 8'hFF;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        DIV  = 2'd1,
        OUT  = 2'd2
    } norm_state_t;

endpackage

// File: rtl/softmax_norm_udiv_seq.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// The caller guarantees dividend < (divisor << QUO_W) so the quotient fits.
module udiv_seq #(
    parameter int DVD_W = 18,
    parameter int DVS_W = 12,
    parameter int QUO_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [QUO_W-1:0] quotient_o
);

    localparam int REM_W = DVS_W + QUO_W;
    localparam int CNT_W = $clog2(QUO_W + 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [QUO_W-1:0] quo_q, quo_d;
    logic [REM_W-1:0] dvs_sh;
    logic             fits;

    // Trial subtraction of the divisor aligned to the current quotient bit.
    always_comb begin
        dvs_sh = REM_W'(dvs_q) << (cnt_q - CNT_W'(1));
        fits   = (rem_q >= dvs_sh);
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(QUO_W);
            rem_d  = REM_W'(dividend_i);
            dvs_d  = divisor_i;
            quo_d  = '0;
        end else if (busy_q) begin
            if (fits) begin
                rem_d = rem_q - dvs_sh;
            end
            quo_d = {quo_q[QUO_W-2:0], fits};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // Control state: iteration counter and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Datapath state: partial remainder, latched divisor, quotient shift register.
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        dvs_q <= dvs_d;
        quo_q <= quo_d;
    end

    // done marks the cycle whose closing edge produces the final quotient bit.
    always_comb begin
        busy_o     = busy_q;
        done_o     = busy_q && (cnt_q == CNT_W'(1));
        quotient_o = quo_q;
    end

endmodule

// File: rtl/softmax_norm.sv
// Softmax row normaliser: buffers one row of UQ3.6 exponents, sums them and
// streams each element divided by the row sum as a UQ0.8 probability.
// Optional macro SOFTMAX_NORM_ROUND_EN: round-to-nearest instead of truncation.
module softmax_norm
    import softmax_pkg::*;
#(
    parameter int ROW_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [EX_W-1:0]   in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [PROB_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int SUM_W = EX_W + $clog2(ROW_LEN);
    localparam int IDX_W = $clog2(ROW_LEN);
    localparam int DVD_W = EX_W + FRAC_OUT + 1;
    localparam int QUO_W = PROB_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

    norm_state_t      state_q, state_d;
    logic [EX_W-1:0]  buf_q [ROW_LEN];
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

    logic             beat, out_fire, row_done, is_last;
    logic             div_start, div_busy, div_done;
    logic [DVD_W-1:0] div_dvd;
    logic [QUO_W-1:0] div_quo;

    function automatic logic [PROB_W-1:0] sat_prob(input logic [QUO_W-1:0] q);
        return q[QUO_W-1] ? PROB_SAT : q[PROB_W-1:0];
    endfunction

    udiv_seq #(
        .DVD_W (DVD_W),
        .DVS_W (SUM_W),
        .QUO_W (QUO_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (div_dvd),
        .divisor_i  (sum_d),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    // Handshake decode shared by the FSM and the datapath.
    always_comb begin
        beat     = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        row_done = (wr_idx_q == LAST_IDX);
        is_last  = (rd_idx_q == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (beat && row_done) state_d = DIV;
            DIV:     if (div_done)         state_d = OUT;
            OUT:     if (out_ready)        state_d = is_last ? FILL : DIV;
            default: state_d = FILL;
        endcase
    end

    // FSM outputs; a zero row sum forces every probability to zero.
    always_comb begin
        in_ready  = (state_q == FILL) && !div_busy;
        out_valid = (state_q == OUT);
        out_last  = out_valid && is_last;
        out_data  = '0;
        if (out_valid && (sum_q != '0)) begin
            out_data = sat_prob(div_quo);
        end
    end

    // Sum, index and divider-launch control. The divider is loaded on the
    // edge that enters DIV, using next-state sum and read index, so DIV
    // lasts exactly the nine iteration cycles.
    always_comb begin
        sum_d     = sum_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        div_start = 1'b0;
        if (beat) begin
            sum_d    = sum_q + SUM_W'(in_data);
            wr_idx_d = wr_idx_q + IDX_W'(1);
            if (row_done) begin
                wr_idx_d  = '0;
                rd_idx_d  = '0;
                div_start = 1'b1;
            end
        end
        if (out_fire) begin
            if (is_last) begin
                sum_d    = '0;
                rd_idx_d = '0;
            end else begin
                rd_idx_d  = rd_idx_q + IDX_W'(1);
                div_start = 1'b1;
            end
        end
        div_dvd = {1'b0, buf_q[rd_idx_d], {FRAC_OUT{1'b0}}};
`ifdef SOFTMAX_NORM_ROUND_EN
        div_dvd = div_dvd + DVD_W'(sum_d >> 1);
`endif
    end

    // Control registers: row sum and buffer indices.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            sum_q    <= sum_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    // Row buffer write; contents are don't-care until a row is filled.
    always_ff @(posedge clk) begin
        if (beat) begin
            buf_q[wr_idx_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_softmax_norm.sv
// Scoreboard bench for softmax_norm (ROW_LEN=8).
module tb_softmax_norm;

    localparam int ROW_LEN = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [8:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_seen = 0;

    int r_64  [ROW_LEN];
    int r_sat [ROW_LEN];
    int r_rnd [ROW_LEN];
    int r_zero[ROW_LEN];
    int r_ramp[ROW_LEN];

    always #5 clk = ~clk;

    softmax_norm #(.ROW_LEN(ROW_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    task automatic check_eq(input string tag, input int obs, input int expv);
        n_cmp++;
        if (obs != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_prob(input int v, input int s);
        int q;
        if (s == 0) return 8'h00;
`ifdef SOFTMAX_NORM_ROUND_EN
        q = (v * 256 + s / 2) / s;
`else
        q = (v * 256) / s;
`endif
        return (q > 255) ? 8'hFF : 8'(q);
    endfunction

    task automatic push_row(input int r[ROW_LEN]);
        int s = 0;
        for (int i = 0; i < ROW_LEN; i++) s += r[i];
        for (int i = 0; i < ROW_LEN; i++) begin
            exp_t e;
            e.data = exp_prob(r[i], s);
            e.last = (i == ROW_LEN - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic drive_row(input int r[ROW_LEN]);
        push_row(r);
        for (int i = 0; i < ROW_LEN; i++) begin
            in_valid = 1'b1;
            in_data  = 9'(r[i]);
            check_eq("in_ready_fill", int'(in_ready), 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", sb_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor: every accepted output is popped and compared.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check_eq("sb_avail", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("out_data", int'(out_data), int'(e.data));
                check_eq("out_last", int'(out_last), int'(e.last));
            end
            n_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int seen_base;
        logic [7:0] hold_d;
        logic       hold_l;

        r_64   = '{default: 64};
        r_sat  = '{511, 0, 0, 0, 0, 0, 0, 0};
        r_rnd  = '{2, 1, 0, 0, 0, 0, 0, 0};
        r_zero = '{default: 0};
        r_ramp = '{10, 20, 30, 40, 50, 60, 70, 80};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_data",  int'(out_data), 0);
        check_eq("rst_out_last",  int'(out_last), 0);
        check_eq("rst_in_ready",  int'(in_ready), 1);

        // Streaming rows with the consumer always ready.
        @(posedge clk);
        #1 out_ready = 1'b1;
        drive_row(r_64);
        wait_drain();
        drive_row(r_sat);
        wait_drain();
        drive_row(r_rnd);
        wait_drain();

        // Zero row, measuring latency from the last input beat.
        drive_row(r_zero);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        check_eq("lat_first_valid", n, 10);
        wait_drain();

        // Back-pressure: consumer stalls on element 3.
        out_ready = 1'b0;
        drive_row(r_ramp);
        for (int e = 0; e < ROW_LEN; e++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 50);
            check_eq("valid_seen", int'(out_valid), 1);
            if (e == 4) check_eq("gap_ge10", int'(n >= 10), 1);
            if (e == 3) begin
                hold_d = out_data;
                hold_l = out_last;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("hold_valid",    int'(out_valid), 1);
                    check_eq("hold_data",     int'(out_data), int'(hold_d));
                    check_eq("hold_last",     int'(out_last), int'(hold_l));
                    check_eq("hold_in_ready", int'(in_ready), 0);
                end
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        check_eq("stall_drained", sb_q.size(), 0);

        // Reset pulse while element 2 is in DIV.
        out_ready = 1'b1;
        seen_base = n_seen;
        drive_row(r_64);
        n = 0;
        while ((n_seen - seen_base) < 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("reach_elem2", n_seen - seen_base, 2);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_out_valid", int'(out_valid), 0);
        check_eq("mid_rst_in_ready",  int'(in_ready), 1);
        sb_q.delete();
        drive_row(r_64);
        wait_drain();

        check_eq("sb_empty_end", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
